register_file: RTL

- Architectural register file serving the pipelined processor core.
- Provides the far end of the core's register-file interface: two combinational read ports, one synchronous write port fed by the write-back stage, and entry 0 hardwired to zero.
- Adds a handshaked debug dump sequencer that streams every entry out for testbench and board-level state inspection.
- Keeps a committed-write counter for the same purpose.

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_file_dump_sequencer.sv | 73 +++++++
 rtl/register_file.sv | 93 +++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing defaults and dump-sequencer state encoding for the architectural register file.
package register_file_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 6;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    function automatic int depth_of(input int address_width);
        return 1 << address_width;
    endfunction

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SCAN = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/register_file_dump_sequencer.sv
// Walks every register-file entry once per dump request and presents it on a valid/ready stream.
module register_file_dump_sequencer
    import register_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     ready,
    input  logic [DATA_WIDTH-1:0]    entry_value,
    output logic                     valid,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    value,
    output dump_state_t              state
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = '1;

    dump_state_t              next_state;
    logic [ADDRESS_WIDTH-1:0] index;
    logic [ADDRESS_WIDTH-1:0] next_index;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DUMP_IDLE;
            index <= '0;
        end else begin
            state <= next_state;
            index <= next_index;
        end
    end

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // valid never drops and address never changes until that transfer happens.
    always_comb begin
        next_state = state;
        next_index = index;
        valid      = 1'b0;
        done       = 1'b0;
        case (state)
            DUMP_IDLE: begin
                if (start) begin
                    next_state = DUMP_SCAN;
                    next_index = '0;
                end
            end
            DUMP_SCAN: begin
                valid = 1'b1;
                if (ready) begin
                    next_index = index + 1'b1;
                    if (index == LAST_INDEX) begin
                        next_state = DUMP_DONE;
                    end
                end
            end
            DUMP_DONE: begin
                done       = 1'b1;
                next_state = DUMP_IDLE;
            end
            default: begin
                next_state = DUMP_IDLE;
            end
        endcase
    end

    assign address = index;
    // The parent returns the bypassed live entry, so a held beat follows in-flight writes.
    assign value   = entry_value;

endmodule

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with write-through bypass,
// one write port, entry 0 hardwired to zero, a debug dump stream and a committed-write counter.
module register_file
    import register_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] register_file_read_address_1,
    input  logic [ADDRESS_WIDTH-1:0] register_file_read_address_2,
    output logic [DATA_WIDTH-1:0]    register_file_read_value_1,
    output logic [DATA_WIDTH-1:0]    register_file_read_value_2,
    input  logic [ADDRESS_WIDTH-1:0] register_file_write_address,
    input  logic [DATA_WIDTH-1:0]    register_file_write_value,
    input  logic                     register_file_write_enable,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDRESS_WIDTH-1:0] dump_address,
    output logic [DATA_WIDTH-1:0]    dump_value,
    output logic                     dump_done,
    output logic [31:0]              write_count
);

    localparam int DEPTH = depth_of(ADDRESS_WIDTH);

    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic                  write_hit;
    logic [DATA_WIDTH-1:0] dump_entry_value;
    dump_state_t           dump_state;

    assign write_hit = register_file_write_enable && (register_file_write_address != '0);

    function automatic logic [DATA_WIDTH-1:0] bypass_read(
        input logic [ADDRESS_WIDTH-1:0] address,
        input logic [DATA_WIDTH-1:0]    stored,
        input logic                     hit,
        input logic [ADDRESS_WIDTH-1:0] write_address,
        input logic [DATA_WIDTH-1:0]    write_value
    );
        if (address == '0) begin
            return '0;
        end else if (hit && (write_address == address)) begin
            return write_value;
        end
        return stored;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            write_count <= '0;
        end else if (write_hit) begin
            entries[register_file_write_address] <= register_file_write_value;
            write_count                          <= write_count + 32'd1;
        end
    end

    always_comb begin
        register_file_read_value_1 = bypass_read(register_file_read_address_1,
            entries[register_file_read_address_1], write_hit,
            register_file_write_address, register_file_write_value);
        register_file_read_value_2 = bypass_read(register_file_read_address_2,
            entries[register_file_read_address_2], write_hit,
            register_file_write_address, register_file_write_value);
        dump_entry_value = bypass_read(dump_address, entries[dump_address], write_hit,
            register_file_write_address, register_file_write_value);
    end

    register_file_dump_sequencer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_dump_sequencer (
        .clock       (clock),
        .reset       (reset),
        .start       (dump_start),
        .ready       (dump_ready),
        .entry_value (dump_entry_value),
        .valid       (dump_valid),
        .done        (dump_done),
        .address     (dump_address),
        .value       (dump_value),
        .state       (dump_state)
    );

    assign dump_busy = (dump_state != DUMP_IDLE);

endmodule
